// File: rtl/myproject_sdiv_36s_5ns_33_seq.sv
// myproject_sdiv_36s_5ns_33_seq: sequential signed-by-unsigned restoring divider, one quotient bit per ce edge
module myproject_sdiv_36s_5ns_33_seq #(
  parameter int ID = 1,
  parameter int din0_WIDTH = 36,
  parameter int din1_WIDTH = 5,
  parameter int dout_WIDTH = 33
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ce,
  input  logic                  start,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH:0]   rem,
  output logic                  done,
  output logic                  busy,
  output logic                  dbz
);
  localparam int W = din0_WIDTH;
  localparam int D = din1_WIDTH;
  localparam int CW = $clog2(W + 1) + (ID - ID);
  localparam logic [1:0] S_IDLE = 2'd0, S_CALC = 2'd1, S_FIX = 2'd2, S_DONE = 2'd3;
  logic [1:0] state_q, state_d;
  logic sgn_q, sgn_d;
  logic [W-1:0] mag_q, mag_d, quo_q, quo_d, res;
  logic [D-1:0] dvs_q, dvs_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [D:0] pr_q, pr_d, shf;
  logic [D+1:0] t;
  logic [dout_WIDTH-1:0] dout_q, dout_d;
  logic [D:0] rem_q, rem_d;
  logic dbz_q, dbz_d, done_q, done_d, busy_q, busy_d, acc;
  assign dout = dout_q;
  assign rem = rem_q;
  assign dbz = dbz_q;
  assign done = done_q;
  assign busy = busy_q;
  always_comb begin
    acc = (state_q == S_IDLE) && start;
    shf = {pr_q[D-1:0], mag_q[W-1]};
    t = {1'b0, shf} - {2'b0, dvs_q};
    res = sgn_q ? -quo_q : quo_q;
    state_d = state_q;
    sgn_d = sgn_q;
    mag_d = mag_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    pr_d = pr_q;
    quo_d = quo_q;
    dout_d = dout_q;
    rem_d = rem_q;
    dbz_d = dbz_q;
    done_d = state_q == S_DONE;
    busy_d = acc | (busy_q & ~done_q);
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_CALC;
        sgn_d = din0[W-1];
        mag_d = din0[W-1] ? -din0 : din0;
        dvs_d = din1;
        cnt_d = CW'(W);
        pr_d = '0;
        quo_d = '0;
      end
      S_CALC: begin
        pr_d = t[D+1] ? shf : t[D:0];
        quo_d = {quo_q[W-2:0], ~t[D+1]};
        mag_d = {mag_q[W-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        state_d = (cnt_q == CW'(1)) ? S_FIX : S_CALC;
      end
      S_FIX: begin
        dbz_d = dvs_q == '0;
        dout_d = dbz_d ? '0 : res[dout_WIDTH-1:0];
        rem_d = dbz_d ? '0 : sgn_q ? -pr_q : pr_q;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
      sgn_q <= 1'b0;
      mag_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      pr_q <= '0;
      quo_q <= '0;
      dout_q <= '0;
      rem_q <= '0;
      dbz_q <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      sgn_q <= sgn_d;
      mag_q <= mag_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
      pr_q <= pr_d;
      quo_q <= quo_d;
      dout_q <= dout_d;
      rem_q <= rem_d;
      dbz_q <= dbz_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end
endmodule
